// File: rtl/accumulate_unit_if.sv
// Handshake bundle between the addend producer, the accumulator and the
// downstream MAC stage. Widths follow the accumulator parameters.
interface accumulate_unit_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 33,
  parameter int CNT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_overflow;

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/accumulate_unit.sv
// Streaming signed group accumulator. Sums sign-extended addends into an
// ACC_W-bit register through a single parallel-prefix carry-lookahead adder,
// counts beats (saturating) and tracks sticky signed overflow, then holds the
// result until the downstream stage takes it.

// Parallel-prefix (Kogge-Stone style) carry-lookahead adder.
module n_bit_cla_adder #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] gk, pk, gn, pn;
  logic [N-1:0] carry;

  // Prefix tree: after log2(N) levels gk[i]/pk[i] are the group
  // generate/propagate over bits [i:0].
  always_comb begin
    gk = a & b;
    pk = a ^ b;
    gn = '0;
    pn = '0;
    for (int l = 0; (1 << l) < N; l++) begin
      gn = gk;
      pn = pk;
      for (int i = (1 << l); i < N; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
        pn[i] = pk[i] & pk[i - (1 << l)];
      end
      gk = gn;
      pk = pn;
    end
  end

  // Carry into bit i comes from the group over bits [i-1:0] plus cin.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < N; i++)
      carry[i] = gk[i-1] | (pk[i-1] & cin);
  end

  assign sum  = (a ^ b) ^ carry;
  assign cout = gk[N-1] | (pk[N-1] & cin);
endmodule

module accumulate_unit #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 33,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  accumulate_unit_if.slave    io
);
  if (ACC_W <= IN_W) begin : g_bad_width
    $error("accumulate_unit: ACC_W must exceed IN_W");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  logic               accept;
  logic               take_out;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   sum;
  logic               ovf_beat;
  logic               cout_unused;

  assign io.in_ready = (state_q != DONE);
  assign accept      = io.in_valid && io.in_ready;
  assign take_out    = (state_q == DONE) && io.out_ready;

  assign addend = {{(ACC_W-IN_W){io.in_data[IN_W-1]}}, io.in_data};

  n_bit_cla_adder #(.N(ACC_W)) u_add (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout_unused)
  );

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_beat = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                    (sum[ACC_W-1]   != acc_q[ACC_W-1]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: accepts move toward DONE, a taken result returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: if (accept) state_d = io.in_last ? DONE : ACC;
      DONE:      if (io.out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: accumulate on accept, clear once the result is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= sum;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      ovf_q <= ovf_q | ovf_beat;
    end else if (take_out) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  assign io.out_valid    = (state_q == DONE);
  assign io.out_sum      = acc_q;
  assign io.out_count    = cnt_q;
  assign io.out_overflow = ovf_q;
endmodule

// File: tb/tb_accumulate_unit.sv
// Directed bench for accumulate_unit: table of groups on the default-width
// unit, hand sequences for reset, backpressure, saturation and mid-group
// reset, a 17-bit instance for overflow, and a reference model checking
// every result handshake on the default unit.
module tb_accumulate_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  accumulate_unit_if #(.IN_W(16), .ACC_W(33), .CNT_W(8)) bus ();
  accumulate_unit_if #(.IN_W(16), .ACC_W(17), .CNT_W(8)) bus17 ();

  accumulate_unit #(.IN_W(16), .ACC_W(33), .CNT_W(8)) u_dut (
    .clk (clk), .rst (rst), .io (bus.slave));
  accumulate_unit #(.IN_W(16), .ACC_W(17), .CNT_W(8)) u_dut17 (
    .clk (clk), .rst (rst), .io (bus17.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model of the default unit, driven only by bench inputs.
  logic [32:0] m_sum;
  logic [7:0]  m_cnt;
  logic        m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum <= '0; m_cnt <= '0; m_done <= 1'b0;
    end else if (m_done) begin
      if (bus.out_ready) begin
        m_sum <= '0; m_cnt <= '0; m_done <= 1'b0;
      end
    end else if (bus.in_valid) begin
      m_sum <= m_sum + {{17{bus.in_data[15]}}, bus.in_data};
      if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
      if (bus.in_last) m_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_out_valid", 64'(bus.out_valid), 64'(m_done));
      if (m_done && bus.out_ready) begin
        chk("mon_sum", 64'(bus.out_sum), 64'(m_sum));
        chk("mon_count", 64'(bus.out_count), 64'(m_cnt));
      end
    end
  end

  // Offer one beat; wait (bounded) for in_ready, then hold across one edge.
  task automatic send_beat(input logic signed [15:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_beat17(input logic signed [15:0] d, input logic last);
    bus17.in_valid = 1'b1; bus17.in_data = d; bus17.in_last = last;
    @(posedge clk); #1;
    bus17.in_valid = 1'b0; bus17.in_last = 1'b0;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_take_valid", 64'(bus.out_valid), 64'd0);
    chk("post_take_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic take_result17();
    bus17.out_ready = 1'b1;
    @(posedge clk); #1;
    bus17.out_ready = 1'b0;
    chk("o17_post_take_valid", 64'(bus17.out_valid), 64'd0);
  endtask

  typedef struct {
    int              nb;
    logic [3:0][15:0] d;
    logic [32:0]     sum;
    logic [7:0]      cnt;
    logic            ovf;
  } vec_t;

  function automatic vec_t mk(int nb, int d0, int d1, int d2, int d3,
                              logic [32:0] s, int c);
    vec_t v;
    v.nb = nb;
    v.d[0] = d0[15:0]; v.d[1] = d1[15:0]; v.d[2] = d2[15:0]; v.d[3] = d3[15:0];
    v.sum = s; v.cnt = c[7:0]; v.ovf = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    tbl[0] = mk(3, 5, -2, 10, 0,                33'd13,            3);
    tbl[1] = mk(1, -1, 0, 0, 0,                 33'h1_FFFF_FFFF,   1);
    tbl[2] = mk(4, 32767, 32767, 32767, 32767,  33'h0_0001_FFFC,   4);
    tbl[3] = mk(4, -32768, -32768, -32768, -32768, 33'h1_FFFE_0000, 4);
    tbl[4] = mk(2, 100, -100, 0, 0,             33'd0,             2);
    tbl[5] = mk(4, 1234, -5000, 7, -32768,      33'h1_FFFF_7151,   4);

    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    bus17.in_valid = 0; bus17.in_data = '0; bus17.in_last = 0; bus17.out_ready = 0;

    // Reset state, observed while reset is held.
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_count", 64'(bus.out_count), 64'd0);
    chk("rst_ovf", 64'(bus.out_overflow), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven groups.
    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < tbl[t].nb; b++)
        send_beat(tbl[t].d[b], (b == tbl[t].nb - 1));
      chk($sformatf("v%0d_valid", t), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d_sum", t), 64'(bus.out_sum), 64'(tbl[t].sum));
      chk($sformatf("v%0d_count", t), 64'(bus.out_count), 64'(tbl[t].cnt));
      chk($sformatf("v%0d_ovf", t), 64'(bus.out_overflow), 64'(tbl[t].ovf));
      chk($sformatf("v%0d_in_ready", t), 64'(bus.in_ready), 64'd0);
      take_result();
    end

    // Backpressure: result held, offered beat not consumed.
    send_beat(16'sd3, 1'b0);
    send_beat(16'sd4, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 16'sd99; bus.in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum", 64'(bus.out_sum), 64'd7);
      chk("bp_count", 64'(bus.out_count), 64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_next_sum", 64'(bus.out_sum), 64'd99);
    chk("bp_next_count", 64'(bus.out_count), 64'd1);
    take_result();

    // Count saturation over 300 beats.
    for (int b = 0; b < 300; b++) send_beat(16'sd1, (b == 299));
    chk("sat_valid", 64'(bus.out_valid), 64'd1);
    chk("sat_sum", 64'(bus.out_sum), 64'd300);
    chk("sat_count", 64'(bus.out_count), 64'd255);
    chk("sat_ovf", 64'(bus.out_overflow), 64'd0);
    take_result();

    // Reset mid-group discards the partial sum.
    send_beat(16'sd7, 1'b0);
    send_beat(16'sd7, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_valid_now", 64'(bus.out_valid), 64'd0);
    chk("mrst_sum_now", 64'(bus.out_sum), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_valid_after", 64'(bus.out_valid), 64'd0);
    chk("mrst_count_after", 64'(bus.out_count), 64'd0);
    send_beat(16'sd1, 1'b0);
    chk("mrst_mid_valid", 64'(bus.out_valid), 64'd0);
    send_beat(16'sd1, 1'b1);
    chk("mrst_res_valid", 64'(bus.out_valid), 64'd1);
    chk("mrst_sum", 64'(bus.out_sum), 64'd2);
    chk("mrst_count", 64'(bus.out_count), 64'd2);
    take_result();

    // 17-bit accumulator: overflow on the third beat.
    send_beat17(16'sd32767, 1'b0);
    send_beat17(16'sd32767, 1'b0);
    chk("o17_no_ovf_yet", 64'(bus17.out_overflow), 64'd0);
    send_beat17(16'sd32767, 1'b1);
    chk("o17_valid", 64'(bus17.out_valid), 64'd1);
    chk("o17_sum", 64'(bus17.out_sum), 64'h17FFD);
    chk("o17_count", 64'(bus17.out_count), 64'd3);
    chk("o17_ovf", 64'(bus17.out_overflow), 64'd1);
    take_result17();

    // Sticky: overflow on beat 3, later beat recovers range, flag stays.
    send_beat17(16'sd32767, 1'b0);
    send_beat17(16'sd32767, 1'b0);
    send_beat17(16'sd32767, 1'b0);
    send_beat17(16'sd5, 1'b1);
    chk("o17s_sum", 64'(bus17.out_sum), 64'h18002);
    chk("o17s_ovf", 64'(bus17.out_overflow), 64'd1);
    take_result17();

    // Flag cleared for the next, non-overflowing group.
    send_beat17(-16'sd5, 1'b0);
    send_beat17(16'sd3, 1'b1);
    chk("o17c_sum", 64'(bus17.out_sum), 64'h1FFFE);
    chk("o17c_ovf", 64'(bus17.out_overflow), 64'd0);
    take_result17();

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accumulate_unit.md
# accumulate_unit

Streaming signed accumulator placed directly downstream of the arithmetic cells. It consumes a stream of signed addends over a valid/ready handshake and sums each group in an `ACC_W`-bit register, using one `n_bit_cla_adder` instance (`N = ACC_W`, `cin = 0`) as its only adder. A group ends on the beat flagged `in_last`. The unit then presents the group sum, the beat count and a sticky signed-overflow flag on an output valid/ready handshake to the next MAC stage.

## Interface
- `IN_W`, 16, width of the signed input addend
- `ACC_W`, 33, accumulator and adder width; must satisfy `ACC_W > IN_W`
- `CNT_W`, 8, beat-counter width
- `clk`  input  1  sole clock; all state changes on the rising edge
- `rst`  input  1  reset, asynchronous and active-high
- `in_valid`  input  1  addend beat offered
- `in_ready`  output  1  unit can accept a beat
- `in_data`  input  IN_W  signed two's-complement addend
- `in_last`  input  1  qualified by `in_valid`; marks the final beat of a group
- `out_valid`  output  1  group result valid
- `out_ready`  input  1  downstream accepts the result
- `out_sum`  output  ACC_W  signed group sum
- `out_count`  output  CNT_W  beats in the group, saturating
- `out_overflow`  output  1  sticky signed overflow within the group

## Operation
- States:
  - IDLE: no beats accepted yet in the current group.
  - ACC: at least one beat accepted, `in_last` not yet seen.
  - DONE: result held for the consumer.
- `in_ready = (state != DONE)`. It is combinational from state, so it reads 1 while reset is asserted.
- Accept means `in_valid && in_ready` at a rising edge.
- On accept:
  - `acc <= acc + sext(in_data)`, computed by the CLA instance.
  - `count <= count + 1`, saturating at `2^CNT_W - 1` with no wrap.
  - `ovf <= ovf | v`, where `v` is 1 when both adder operands have the same sign and the sum's MSB differs from it.
  - On overflow, `acc` keeps the wrapped ACC_W-bit sum.
- State transitions:
  - IDLE or ACC, accept with `in_last = 0`: go to ACC.
  - IDLE or ACC, accept with `in_last = 1`: go to DONE.
  - No accept: state unchanged.
- DONE:
  - `out_valid = 1`; `out_sum`, `out_count` and `out_overflow` are driven from the registered acc, count and ovf, and are stable until the handshake completes.
  - On `out_valid && out_ready`: acc, count and ovf clear to 0 and the state goes to IDLE.
  - `in_valid` is ignored (`in_ready = 0`).
- A group of one beat is legal.
- `in_last` without `in_valid` has no effect.
- Outputs outside DONE: `out_valid = 0`; `out_sum`, `out_count` and `out_overflow` show the running values and carry no meaning.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state = IDLE; acc, count and ovf = 0.
  - `out_valid = 0`, `out_sum = 0`, `out_count = 0`, `out_overflow = 0`, `in_ready = 1`.
- Latency: a last beat accepted at edge k makes `out_valid` high immediately after edge k. The result is observable in cycle k+1.
- Handshake at edge j (`out_valid && out_ready`):
  - `in_ready` returns to 1 after edge j.
  - The earliest next beat is accepted at edge j+1.
  - Throughput is one beat per cycle within a group, plus one dead input cycle per group.
- Reset asserted mid-group or during DONE discards the partial or held result immediately; no `out_valid` is produced for it.
- The adder path is a single cycle; there are no multicycle paths.

## Test plan
- Basic group: beats 5, -2, 10 (last on the third) -> after the third accept, `out_valid = 1`, `out_sum = 13`, `out_count = 3`, `out_overflow = 0`. With `out_ready = 1` the unit returns to IDLE in the next cycle.
- Single beat, all ones: one beat -1 with `in_last`, defaults -> `out_sum = 33'h1_FFFF_FFFF`, `out_count = 1`, `out_overflow = 0`.
- Overflow, `ACC_W = 17`: three beats 32767 -> `out_overflow = 1` (set on the third beat) and `out_sum` equals 98301 mod 2^17 read as signed = -32771.
- Backpressure: hold `out_ready = 0` for 5 cycles in DONE while driving `in_valid = 1` -> outputs stable, `in_ready = 0`, no beat consumed. Raising `out_ready` completes the handshake, and the next beat is accepted one cycle later.
- Count saturation: 300 beats of +1, last on the 300th -> `out_sum = 300`, `out_count = 255`, `out_overflow = 0`.
- Reset mid-group: 2 beats of 7, assert `rst` for 1 cycle, then beats 1 and 1 with last -> `out_sum = 2`, `out_count = 2`. `out_valid` is 0 throughout and immediately after reset.
- Random check, all tests: compare against a golden model of the sum of sign-extended beats mod 2^ACC_W at every `out_valid && out_ready`.
